// File: rtl/serial_word_pkg.sv
// serial_word_pkg: shared constants and output-state type for serial_word_collector
package serial_word_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int CNT_W = $clog2(DEF_WIDTH);
  typedef enum logic {EMPTY, FULL} out_state_t;
endpackage

// File: rtl/dff_en.sv
// dff_en: D flip-flop with enable and synchronous active-low reset
//   clk, rst_n: clock and reset; en: load d when 1; d: data in; q: registered data out
module dff_en (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk)
    if (!rst_n) q <= 1'b0;
    else if (en) q <= d;
endmodule

// File: rtl/serial_word_collector.sv
// serial_word_collector: assembles qualified serial bits into WIDTH-bit words behind a one-word valid/ready holding register
//   din/din_valid: serial input; dout/dout_valid/dout_ready: word handshake;
//   bit_cnt: bits in the partial word; overrun/clear_ovr: sticky drop flag and its clear
module serial_word_collector
  import serial_word_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din,
  input  logic                     din_valid,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun,
  input  logic                     clear_ovr
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] sr, nxt;
  out_state_t state, state_nxt;
  logic complete, load, drop;
  // nxt is the shift contents with din merged in; on the completing edge it is the whole word
  assign nxt = MSB_FIRST ? {sr[WIDTH-2:0], din} : {din, sr[WIDTH-1:1]};
  assign complete = din_valid && (bit_cnt == CW'(WIDTH - 1));
  assign load = complete && (state == EMPTY || dout_ready);
  assign drop = complete && state == FULL && !dout_ready;
  assign dout_valid = (state == FULL);
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      dff_en u_sr (.clk(clk), .rst_n(rst_n), .en(din_valid), .d(nxt[i]), .q(sr[i]));
      dff_en u_do (.clk(clk), .rst_n(rst_n), .en(load), .d(nxt[i]), .q(dout[i]));
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      bit_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (din_valid) bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
      overrun <= drop | (overrun & ~clear_ovr);
    end
  end
  // a word completing while FULL and accepted keeps the register FULL with the new word
  always_comb begin
    state_nxt = state;
    state_nxt = (state == EMPTY) ? (complete ? FULL : EMPTY)
                                 : ((dout_ready && !complete) ? EMPTY : FULL);
  end
endmodule

// File: tb/tb_serial_word_collector.sv
// tb_serial_word_collector: table vectors, hand sequences and a scoreboarded random stream for both bit orders
module tb_serial_word_collector;
  logic clk = 1'b0;
  logic rst_n, din, din_valid, dout_ready, clear_ovr;
  logic [7:0] dout_m, dout_l;
  logic dv_m, dv_l, ov_m, ov_l;
  logic [2:0] cnt_m, cnt_l;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  serial_word_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .dout(dout_m), .dout_valid(dv_m),
    .dout_ready(dout_ready), .bit_cnt(cnt_m), .overrun(ov_m), .clear_ovr(clear_ovr));
  serial_word_collector #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .dout(dout_l), .dout_valid(dv_l),
    .dout_ready(dout_ready), .bit_cnt(cnt_l), .overrun(ov_l), .clear_ovr(clear_ovr));

  typedef struct {
    bit r, d, v, rd, c;
    logic [7:0] em, el;
    bit ev;
    logic [2:0] ec;
    bit eo;
  } vec_t;
  vec_t tbl[11];

  function automatic vec_t mk(bit r, bit d, bit v, bit rd, bit c, logic [7:0] em, logic [7:0] el,
                              bit ev, logic [2:0] ec, bit eo);
    vec_t t;
    t.r = r; t.d = d; t.v = v; t.rd = rd; t.c = c;
    t.em = em; t.el = el; t.ev = ev; t.ec = ec; t.eo = eo;
    return t;
  endfunction

  function automatic logic [7:0] rev8(logic [7:0] w);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = w[7-k];
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(bit r, bit d, bit v, bit rd, bit c);
    rst_n = r; din = d; din_valid = v; dout_ready = rd; clear_ovr = c;
    @(posedge clk);
    #1;
  endtask

  // both instances see the same inputs, so their status outputs must agree with one expectation
  task automatic chk_both(string name, logic [7:0] em, bit ev, logic [2:0] ec, bit eo);
    chk({name, " dout_msb"}, {24'd0, dout_m}, {24'd0, em});
    chk({name, " dout_lsb"}, {24'd0, dout_l}, {24'd0, rev8(em)});
    chk({name, " valid"}, {30'd0, dv_m, dv_l}, {30'd0, ev, ev});
    chk({name, " cnt"}, {26'd0, cnt_m, cnt_l}, {26'd0, ec, ec});
    chk({name, " ovr"}, {30'd0, ov_m, ov_l}, {30'd0, eo, eo});
  endtask

  // sends a word MSB-first with optional idle gaps; rd_last overrides ready on the final bit
  task automatic send_word(logic [7:0] w, bit rd, bit rd_last, bit gaps);
    for (int k = 7; k >= 0; k--) begin
      cyc(1, w[k], 1, (k == 0) ? rd_last : rd, 0);
      if (gaps && k != 0) begin
        int n = 1 + (k % 3);
        for (int g = 0; g < n; g++) begin
          cyc(1, ~w[k], 0, rd, 0);
          chk("gap cnt_hold", {29'd0, cnt_m}, 32'(8 - k));
        end
      end
    end
  endtask

  initial begin
    logic [7:0] acc;
    int n;
    bit done;
    tbl[0] = mk(0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    tbl[1] = mk(0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    for (int k = 0; k < 7; k++)
      tbl[2+k] = mk(1, (k < 2), 1, 1, 0, 8'h00, 8'h00, 0, 3'(k + 1), 0);
    tbl[9]  = mk(1, 0, 1, 1, 0, 8'hC0, 8'h03, 1, 0, 0);
    tbl[10] = mk(1, 0, 0, 1, 0, 8'hC0, 8'h03, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) begin
      cyc(tbl[k].r, tbl[k].d, tbl[k].v, tbl[k].rd, tbl[k].c);
      chk($sformatf("tbl%0d dout_msb", k), {24'd0, dout_m}, {24'd0, tbl[k].em});
      chk($sformatf("tbl%0d dout_lsb", k), {24'd0, dout_l}, {24'd0, tbl[k].el});
      chk($sformatf("tbl%0d valid", k), {31'd0, dv_m}, {31'd0, tbl[k].ev});
      chk($sformatf("tbl%0d cnt", k), {29'd0, cnt_m}, {29'd0, tbl[k].ec});
      chk($sformatf("tbl%0d ovr", k), {31'd0, ov_m}, {31'd0, tbl[k].eo});
    end
    send_word(8'hC0, 1, 1, 1);
    chk_both("gaps word", 8'hC0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    chk_both("gaps drain", 8'hC0, 0, 0, 0);
    send_word(8'hC0, 0, 0, 0);
    chk_both("ovr first", 8'hC0, 1, 0, 0);
    send_word(8'h5A, 0, 0, 0);
    chk_both("ovr second", 8'hC0, 1, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk_both("ovr clear", 8'hC0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    chk_both("ovr drain", 8'hC0, 0, 0, 0);
    send_word(8'hC0, 0, 0, 0);
    chk_both("same-edge first", 8'hC0, 1, 0, 0);
    send_word(8'h5A, 0, 1, 0);
    chk_both("same-edge second", 8'h5A, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    chk_both("same-edge drain", 8'h5A, 0, 0, 0);
    cyc(1, 1, 1, 1, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);
    chk("partial cnt", {29'd0, cnt_m}, 32'd3);
    cyc(0, 1, 1, 1, 1);
    chk_both("mid reset", 8'h00, 0, 0, 0);
    send_word(8'h3C, 1, 1, 0);
    chk_both("post reset", 8'h3C, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    // random stream with ready held high: every completed word appears for exactly one cycle
    n = 0;
    acc = '0;
    for (int t = 0; t < 300; t++) begin
      bit v, d;
      v = ($urandom_range(3) != 0);
      d = 1'($urandom_range(1));
      done = 0;
      if (v) begin
        acc = {acc[6:0], d};
        n++;
        if (n == 8) begin
          sb.push_back(acc);
          n = 0;
          done = 1;
        end
      end
      cyc(1, d, v, 1, 0);
      chk("rnd valid", {31'd0, dv_m}, {31'd0, done});
      chk("rnd cnt", {29'd0, cnt_l}, 32'(n));
      if (dv_m) begin
        if (sb.size() == 0) chk("rnd sb_underflow", 32'd1, 32'd0);
        else begin
          logic [7:0] e;
          e = sb.pop_front();
          chk("rnd dout_msb", {24'd0, dout_m}, {24'd0, e});
          chk("rnd dout_lsb", {24'd0, dout_l}, {24'd0, rev8(e)});
        end
      end
    end
    chk("rnd sb_left", 32'(sb.size()), 32'd0);
    chk("rnd ovr", {30'd0, ov_m, ov_l}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
